// File: rtl/sevenseg_scan_ctrl.sv
// Memory-mapped, time-multiplexed multi-digit 7-segment display controller.
// Optional PWM brightness control is enabled by defining SEVENSEG_BRIGHTNESS_EN.
module sevenseg_scan_ctrl #(
  parameter int              XLEN           = 32,
  parameter int              NUM_DIGITS     = 4,
  parameter int              SCAN_DIV       = 1000,
  parameter logic [XLEN-1:0] BASE_ADDR      = 'h400,
  parameter int              SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [XLEN-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]       wr_data_i,
  input  logic                  rd_en_i,
  input  logic [XLEN-1:0]       rd_addr_i,
  output logic [XLEN-1:0]       rd_data_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  update_o
);

  localparam int   IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   PS_W   = $clog2(SCAN_DIV);
  localparam logic ACT_LO = (SEG_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_e;

  typedef struct packed {
    logic             ctrl;
    logic             digit;
    logic [IDX_W-1:0] idx;
  } addr_hit_t;

  // Only word-aligned CTRL and DIGIT[0..NUM_DIGITS-1] are mapped.
  function automatic addr_hit_t decode_addr(input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] off;
    logic [XLEN-1:0] word;
    addr_hit_t       h;
    off     = addr - BASE_ADDR;
    word    = off >> 2;
    h.ctrl  = (off == '0);
    h.digit = (off[1:0] == 2'b00) && (word != '0) && (word <= XLEN'(NUM_DIGITS));
    h.idx   = IDX_W'(word - XLEN'(1));
    return h;
  endfunction

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  logic                  en_q, en_d;
  logic                  hex_q, hex_d;
  logic [7:0]            digit_q [NUM_DIGITS];
  logic [7:0]            digit_d [NUM_DIGITS];
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PS_W-1:0]       presc_q, presc_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;
  logic                  update_q, update_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  an_gate;
  logic [7:0]            cur_digit;
  addr_hit_t             wr_hit, rd_hit;
`ifdef SEVENSEG_BRIGHTNESS_EN
  logic [3:0]            bright_q, bright_d;
  logic [3:0]            pwm_q, pwm_d;
`endif

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    wr_hit    = decode_addr(wr_addr_i);
    rd_hit    = decode_addr(rd_addr_i);
    en_d      = en_q;
    hex_d     = hex_q;
    update_d  = 1'b0;
    rd_data_d = rd_data_q;
    for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = digit_q[i];
`ifdef SEVENSEG_BRIGHTNESS_EN
    bright_d = bright_q;
`endif

    if (wr_en_i && wr_hit.ctrl) begin
      en_d  = wr_data_i[0];
      hex_d = wr_data_i[1];
`ifdef SEVENSEG_BRIGHTNESS_EN
      bright_d = wr_data_i[11:8];
`endif
    end
    if (wr_en_i && wr_hit.digit) begin
      digit_d[wr_hit.idx] = wr_data_i[7:0];
      update_d            = (wr_data_i[7:0] != digit_q[wr_hit.idx]);
    end

    // Reads see the pre-write register values.
    if (rd_en_i) begin
      rd_data_d = '0;
      if (rd_hit.ctrl) begin
        rd_data_d[0] = en_q;
        rd_data_d[1] = hex_q;
`ifdef SEVENSEG_BRIGHTNESS_EN
        rd_data_d[11:8] = bright_q;
`endif
      end else if (rd_hit.digit) begin
        rd_data_d[7:0] = digit_q[rd_hit.idx];
      end
    end

    // The incoming EN value steers the scan, so a CTRL write beats a scan step.
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = '0;
    if (!en_d) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SCAN;
          idx_d   = '0;
        end
        SCAN: begin
          if (presc_q == PS_W'(SCAN_DIV - 1)) state_d = BLANK;
          else                                presc_d = presc_q + 1'b1;
        end
        default: begin
          state_d = SCAN;
          idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
      endcase
    end

`ifdef SEVENSEG_BRIGHTNESS_EN
    pwm_d   = (state_q == SCAN && state_d == SCAN) ? pwm_q + 4'd1 : 4'd0;
    an_gate = (pwm_d < bright_d);
`else
    an_gate = 1'b1;
`endif

    // Pin registers are computed from next-state values so they track the FSM with no lag.
    cur_digit = digit_d[idx_d];
    an_d      = '0;
    seg_d     = '0;
    dp_d      = 1'b0;
    if (state_d == SCAN) begin
      an_d[idx_d] = an_gate;
      seg_d       = hex_d ? hex_decode(cur_digit[3:0]) : cur_digit[6:0];
      dp_d        = cur_digit[7];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q      <= 1'b0;
      hex_q     <= 1'b0;
      // NOTE: the digit file is small and readable over the bus, so it is reset like any register.
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      presc_q   <= '0;
      rd_data_q <= '0;
      update_q  <= 1'b0;
      an_q      <= {NUM_DIGITS{ACT_LO}};
      seg_q     <= {7{ACT_LO}};
      dp_q      <= ACT_LO;
`ifdef SEVENSEG_BRIGHTNESS_EN
      bright_q  <= 4'hF;
      pwm_q     <= '0;
`endif
    end else begin
      en_q      <= en_d;
      hex_q     <= hex_d;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
      state_q   <= state_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      rd_data_q <= rd_data_d;
      update_q  <= update_d;
      an_q      <= an_d ^ {NUM_DIGITS{ACT_LO}};
      seg_q     <= seg_d ^ {7{ACT_LO}};
      dp_q      <= dp_d ^ ACT_LO;
`ifdef SEVENSEG_BRIGHTNESS_EN
      bright_q  <= bright_d;
      pwm_q     <= pwm_d;
`endif
    end
  end

  assign rd_data_o = rd_data_q;
  assign update_o  = update_q;
  assign an_o      = an_q;
  assign seg_o     = seg_q;
  assign dp_o      = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed self-checking bench for sevenseg_scan_ctrl (4 digits, 4-cycle scan).
module tb_sevenseg_scan_ctrl;

  localparam logic [31:0] CTRL_A = 32'h400;
  localparam logic [31:0] DIG0_A = 32'h404;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wr_en_i;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic        rd_en_i;
  logic [31:0] rd_addr_i;
  logic [31:0] rd_data_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        update_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  sevenseg_scan_ctrl #(
    .XLEN(32), .NUM_DIGITS(4), .SCAN_DIV(4), .BASE_ADDR(32'h400), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o), .update_o(update_o)
  );

  always #5 clk = ~clk;

  // All tasks start and end at a falling edge; outputs are sampled there.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    wr_en_i = 1'b1; wr_addr_i = addr; wr_data_i = data;
    @(negedge clk);
    wr_en_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    rd_en_i = 1'b1; rd_addr_i = addr;
    @(negedge clk);
    rd_en_i = 1'b0;
    data = rd_data_o;
  endtask

  task automatic wait_an(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (an_o === want) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    n_checks++; if (an_o !== 4'b0000) begin n_fail++; $display("FAIL reset_an got=%b exp=0000", an_o); end
    n_checks++; if (seg_o !== 7'h00) begin n_fail++; $display("FAIL reset_seg got=%h exp=00", seg_o); end
    n_checks++; if (dp_o !== 1'b0) begin n_fail++; $display("FAIL reset_dp got=%b exp=0", dp_o); end
    n_checks++; if (update_o !== 1'b0) begin n_fail++; $display("FAIL reset_update got=%b exp=0", update_o); end
    n_checks++; if (rd_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data_o); end
    bus_read(CTRL_A, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl_read got=%h exp=0", r); end
    bus_write(CTRL_A, 32'h1);
    for (int t = 0; t < 10; t++) begin
      n_checks++; if (seg_o !== 7'h00) begin n_fail++; $display("FAIL empty_scan_seg t=%0d got=%h exp=00", t, seg_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_hex_scan();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    for (int i = 0; i < 4; i++) bus_write(DIG0_A + 32'(4 * i), 32'(i + 1));
    bus_write(CTRL_A, 32'h0);
    bus_write(CTRL_A, 32'h3);
    for (int t = 0; t < 40; t++) begin
      if ((t % 5) < 4) begin
        exp_an  = 4'(1 << ((t / 5) % 4));
        exp_seg = hex_tab[((t / 5) % 4) + 1];
      end else begin
        exp_an  = 4'b0000;
        exp_seg = 7'h00;
      end
      n_checks++; if (an_o !== exp_an) begin n_fail++; $display("FAIL hex_scan_an t=%0d got=%b exp=%b", t, an_o, exp_an); end
      n_checks++; if (seg_o !== exp_seg) begin n_fail++; $display("FAIL hex_scan_seg t=%0d got=%h exp=%h", t, seg_o, exp_seg); end
      @(negedge clk);
    end
  endtask

  task automatic test_raw_dp();
    bit ok;
    bus_write(DIG0_A + 32'd8, 32'hFF);
    bus_write(CTRL_A, 32'h0);
    bus_write(CTRL_A, 32'h1);
    n_checks++; if (an_o !== 4'b0001) begin n_fail++; $display("FAIL raw_an0 got=%b exp=0001", an_o); end
    n_checks++; if (seg_o !== 7'h01) begin n_fail++; $display("FAIL raw_seg0 got=%h exp=01", seg_o); end
    n_checks++; if (dp_o !== 1'b0) begin n_fail++; $display("FAIL raw_dp0 got=%b exp=0", dp_o); end
    wait_an(4'b0100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL raw_wait_digit2 got=timeout exp=an 0100"); end
    n_checks++; if (seg_o !== 7'h7F) begin n_fail++; $display("FAIL raw_seg2 got=%h exp=7f", seg_o); end
    n_checks++; if (dp_o !== 1'b1) begin n_fail++; $display("FAIL raw_dp2 got=%b exp=1", dp_o); end
  endtask

  task automatic test_update_and_map();
    logic [31:0] r;
    bus_write(DIG0_A + 32'd4, 32'h05);
    n_checks++; if (update_o !== 1'b1) begin n_fail++; $display("FAIL update_first got=%b exp=1", update_o); end
    @(negedge clk);
    n_checks++; if (update_o !== 1'b0) begin n_fail++; $display("FAIL update_single got=%b exp=0", update_o); end
    bus_write(DIG0_A + 32'd4, 32'h05);
    n_checks++; if (update_o !== 1'b0) begin n_fail++; $display("FAIL update_rewrite got=%b exp=0", update_o); end
    bus_write(CTRL_A, 32'hFFFF_FFFF);
    n_checks++; if (update_o !== 1'b0) begin n_fail++; $display("FAIL update_ctrl got=%b exp=0", update_o); end
    bus_read(CTRL_A, r);
    n_checks++; if (r !== 32'h3) begin n_fail++; $display("FAIL ctrl_read_mask got=%h exp=3", r); end
    bus_write(CTRL_A, 32'h1);
    bus_write(CTRL_A + 32'h40, 32'hAB);
    n_checks++; if (update_o !== 1'b0) begin n_fail++; $display("FAIL update_unmapped got=%b exp=0", update_o); end
    bus_read(CTRL_A + 32'h40, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=0", r); end
    bus_read(DIG0_A + 32'd4, r);
    n_checks++; if (r !== 32'h05) begin n_fail++; $display("FAIL digit1_read got=%h exp=05", r); end
    bus_write(DIG0_A + 32'd12, 32'hFFFF_FF12);
    bus_read(DIG0_A + 32'd12, r);
    n_checks++; if (r !== 32'h12) begin n_fail++; $display("FAIL digit3_mask got=%h exp=12", r); end
    repeat (3) @(negedge clk);
    n_checks++; if (rd_data_o !== 32'h12) begin n_fail++; $display("FAIL read_hold got=%h exp=12", rd_data_o); end
    // Same-cycle write and read of DIGIT0 returns the old value.
    wr_en_i = 1'b1; wr_addr_i = DIG0_A; wr_data_i = 32'h77;
    rd_en_i = 1'b1; rd_addr_i = DIG0_A;
    @(negedge clk);
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    n_checks++; if (rd_data_o !== 32'h01) begin n_fail++; $display("FAIL rw_same_old got=%h exp=01", rd_data_o); end
    bus_read(DIG0_A, r);
    n_checks++; if (r !== 32'h77) begin n_fail++; $display("FAIL rw_same_new got=%h exp=77", r); end
  endtask

  task automatic test_disable_mid_scan();
    bit ok;
    wait_an(4'b0100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL dis_wait_digit2 got=timeout exp=an 0100"); end
    bus_write(CTRL_A, 32'h0);
    n_checks++; if (an_o !== 4'b0000) begin n_fail++; $display("FAIL dis_an got=%b exp=0000", an_o); end
    n_checks++; if (seg_o !== 7'h00) begin n_fail++; $display("FAIL dis_seg got=%h exp=00", seg_o); end
    repeat (3) @(negedge clk);
    n_checks++; if (an_o !== 4'b0000) begin n_fail++; $display("FAIL dis_idle_an got=%b exp=0000", an_o); end
    bus_write(CTRL_A, 32'h1);
    n_checks++; if (an_o !== 4'b0001) begin n_fail++; $display("FAIL reen_an got=%b exp=0001", an_o); end
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] r;
    bit ok;
    wait_an(4'b0010, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_wait_digit1 got=timeout exp=an 0010"); end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    n_checks++; if (an_o !== 4'b0000) begin n_fail++; $display("FAIL rstmid_an got=%b exp=0000", an_o); end
    n_checks++; if (seg_o !== 7'h00) begin n_fail++; $display("FAIL rstmid_seg got=%h exp=00", seg_o); end
    n_checks++; if (dp_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_dp got=%b exp=0", dp_o); end
    n_checks++; if (rd_data_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_rd_data got=%h exp=0", rd_data_o); end
    bus_read(CTRL_A, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rstmid_ctrl got=%h exp=0", r); end
    for (int i = 0; i < 4; i++) begin
      bus_read(DIG0_A + 32'(4 * i), r);
      n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rstmid_digit%0d got=%h exp=0", i, r); end
    end
    n_checks++; if (an_o !== 4'b0000) begin n_fail++; $display("FAIL rstmid_idle_an got=%b exp=0000", an_o); end
  endtask

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    rd_en_i = 1'b0; rd_addr_i = '0;
    test_reset();
    test_hex_scan();
    test_raw_dp();
    test_update_and_map();
    test_disable_mid_scan();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
